// File: rtl/fifo_word_packer_pkg.sv
// Shared definitions for the FIFO read-side word packer: state encoding,
// parameter defaults and the byte-count width helper.
package fifo_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_PACK       = 4;

    // Wide enough to hold every count from 0 through PACK inclusive.
    function automatic int BYTES_W(input int pack);
        return $clog2(pack) + 1;
    endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// Bundles the FIFO read port and the packed-word handshake of the packer.
// master = packer side, slave = FIFO/consumer side.
interface fifo_word_packer_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PACK       = DEFAULT_PACK
);

    logic [DATA_WIDTH-1:0]      fifo_data_out;
    logic                       fifo_empty;
    logic                       Read_enable;
    logic                       flush;
    logic [PACK*DATA_WIDTH-1:0] word_out;
    logic                       word_valid;
    logic [BYTES_W(PACK)-1:0]   word_bytes;
    logic                       word_ready;

    modport master (
        input  fifo_data_out,
        input  fifo_empty,
        input  flush,
        input  word_ready,
        output Read_enable,
        output word_out,
        output word_valid,
        output word_bytes
    );

    modport slave (
        output fifo_data_out,
        output fifo_empty,
        output flush,
        output word_ready,
        input  Read_enable,
        input  word_out,
        input  word_valid,
        input  word_bytes
    );

endinterface

// File: rtl/fifo_word_packer.sv
// Drains FIFO entries, packs them little-endian into PACK-entry words and
// offers each word on a valid/ready handshake; flush releases a partial word.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PACK       = DEFAULT_PACK
) (
    input  logic               read_clk,
    input  logic               reset,
    fifo_word_packer_if.master bus
);

    localparam int              BW     = BYTES_W(PACK);
    localparam int              WW     = PACK * DATA_WIDTH;
    localparam logic [BW-1:0]   PACK_C = BW'(PACK);

    state_t          state_q,     state_d;
    logic [BW-1:0]   count_q,     count_d;
    logic            pending_q,   pending_d;
    logic            flush_req_q, flush_req_d;
    logic            valid_q,     valid_d;
    logic [WW-1:0]   word_q,      word_d;
    logic [BW-1:0]   bytes_q,     bytes_d;
    logic            read_en;

    // Reads are throttled so that captured plus in-flight entries never
    // exceed one word; a latched flush also stops further reads.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pending_d   = pending_q;
        flush_req_d = flush_req_q;
        valid_d     = valid_q;
        word_d      = word_q;
        bytes_d     = bytes_q;
        read_en     = 1'b0;

        if (state_q == FILL) begin
            read_en = reset && !flush_req_q && !bus.fifo_empty &&
                      ((count_q + BW'(pending_q)) < PACK_C);
            pending_d = read_en;

            if (pending_q) begin
                if (count_q == '0) begin
                    word_d = '0;
                end
                for (int i = 0; i < PACK; i++) begin
                    if (count_q == BW'(i)) begin
                        word_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_data_out;
                    end
                end
                count_d = count_q + 1'b1;
            end

            if (bus.flush && ((count_q != '0) || pending_q)) begin
                flush_req_d = 1'b1;
            end

            // A word that fills up wins over a flush arriving alongside it.
            if ((count_d == PACK_C) ||
                (flush_req_d && (count_d != '0) && !pending_d)) begin
                state_d     = HOLD;
                valid_d     = 1'b1;
                bytes_d     = count_d;
                flush_req_d = 1'b0;
            end
        end else begin
            pending_d = 1'b0;
            if (valid_q && bus.word_ready) begin
                state_d     = FILL;
                count_d     = '0;
                flush_req_d = 1'b0;
                valid_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge read_clk) begin
        if (!reset) begin
            state_q     <= FILL;
            count_q     <= '0;
            pending_q   <= 1'b0;
            flush_req_q <= 1'b0;
            valid_q     <= 1'b0;
            word_q      <= '0;
            bytes_q     <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            flush_req_q <= flush_req_d;
            valid_q     <= valid_d;
            word_q      <= word_d;
            bytes_q     <= bytes_d;
        end
    end

    assign bus.Read_enable = read_en;
    assign bus.word_out    = word_q;
    assign bus.word_valid  = valid_q;
    assign bus.word_bytes  = bytes_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a simple one-cycle-latency FIFO
// model; outputs are sampled on the falling clock edge.
module tb_fifo_word_packer;
    import fifo_pkg::*;

    localparam int DW = 8;
    localparam int PK = 4;

    logic read_clk = 1'b0;
    logic reset;

    fifo_word_packer_if #(.DATA_WIDTH(DW), .PACK(PK)) bus ();

    fifo_word_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
        .read_clk (read_clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 read_clk = ~read_clk;

    logic [7:0] mem [0:63];
    int         wr_ptr    = 0;
    int         rd_ptr    = 0;
    logic       underflow = 1'b0;
    int         checks    = 0;
    int         errors    = 0;

    assign bus.fifo_empty = (rd_ptr == wr_ptr);

    // FIFO model: data appears one cycle after the read strobe.
    always @(posedge read_clk) begin
        if (bus.Read_enable) begin
            if (rd_ptr == wr_ptr) begin
                underflow <= 1'b1;
            end else begin
                bus.fifo_data_out <= mem[rd_ptr[5:0]];
                rd_ptr            <= rd_ptr + 1;
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] v);
        mem[wr_ptr[5:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitValid(input int max_cycles, output int reads, output int cycles);
        reads  = 0;
        cycles = 0;
        while (!bus.word_valid && cycles < max_cycles) begin
            if (bus.Read_enable) reads++;
            @(negedge read_clk);
            cycles++;
        end
    endtask

    initial begin
        int reads;
        int cycles;

        reset          = 1'b0;
        bus.flush      = 1'b0;
        bus.word_ready = 1'b1;
        applyStimulus(8'h00);
        applyStimulus(8'h55);
        applyStimulus(8'hAA);
        applyStimulus(8'hFF);

        repeat (3) begin
            @(negedge read_clk);
            checkOutput("rst_read_enable", 64'(bus.Read_enable), 64'h0);
            checkOutput("rst_word_valid",  64'(bus.word_valid),  64'h0);
            checkOutput("rst_word_out",    64'(bus.word_out),    64'h0);
        end
        checkOutput("rst_word_bytes", 64'(bus.word_bytes), 64'h0);

        // Full word, consumer always ready
        reset = 1'b1;
        #1;
        waitValid(20, reads, cycles);
        checkOutput("full_valid",  64'(bus.word_valid), 64'h1);
        checkOutput("full_reads",  64'(reads),          64'd4);
        checkOutput("full_cycles", 64'(cycles),         64'd5);
        checkOutput("full_word",   64'(bus.word_out),   64'hFFAA5500);
        checkOutput("full_bytes",  64'(bus.word_bytes), 64'd4);
        @(negedge read_clk);
        checkOutput("full_accept", 64'(bus.word_valid), 64'h0);

        // Backpressure with two words queued
        bus.word_ready = 1'b0;
        for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
        #1;
        waitValid(20, reads, cycles);
        checkOutput("bp1_valid",  64'(bus.word_valid), 64'h1);
        checkOutput("bp1_reads",  64'(reads),          64'd4);
        checkOutput("bp1_word",   64'(bus.word_out),   64'h04030201);
        checkOutput("bp1_bytes",  64'(bus.word_bytes), 64'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge read_clk);
            checkOutput("bp_word_stable", 64'(bus.word_out),    64'h04030201);
            checkOutput("bp_no_read",     64'(bus.Read_enable), 64'h0);
            checkOutput("bp_valid_held",  64'(bus.word_valid),  64'h1);
        end
        bus.word_ready = 1'b1;
        @(negedge read_clk);
        checkOutput("bp1_accept", 64'(bus.word_valid), 64'h0);
        waitValid(20, reads, cycles);
        checkOutput("bp2_valid",  64'(bus.word_valid), 64'h1);
        checkOutput("bp2_reads",  64'(reads),          64'd4);
        checkOutput("bp2_cycles", 64'(cycles),         64'd5);
        checkOutput("bp2_word",   64'(bus.word_out),   64'h08070605);
        @(negedge read_clk);
        checkOutput("bp2_accept", 64'(bus.word_valid), 64'h0);

        // Partial word released by flush
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        #1;
        repeat (5) @(negedge read_clk);
        checkOutput("flush_no_word", 64'(bus.word_valid),  64'h0);
        checkOutput("flush_idle",    64'(bus.Read_enable), 64'h0);
        bus.flush = 1'b1;
        @(negedge read_clk);
        bus.flush = 1'b0;
        checkOutput("flush_valid", 64'(bus.word_valid), 64'h1);
        checkOutput("flush_word",  64'(bus.word_out),   64'h00002211);
        checkOutput("flush_bytes", 64'(bus.word_bytes), 64'd2);
        @(negedge read_clk);
        checkOutput("flush_accept", 64'(bus.word_valid), 64'h0);

        // Flush with nothing captured is ignored
        bus.flush = 1'b1;
        @(negedge read_clk);
        bus.flush = 1'b0;
        repeat (3) @(negedge read_clk);
        checkOutput("flush_empty_word", 64'(bus.word_valid), 64'h0);

        // Flush one cycle after a read: in-flight entries join the word
        bus.word_ready = 1'b0;
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        applyStimulus(8'h55);
        #1;
        checkOutput("pf_first_read", 64'(bus.Read_enable), 64'h1);
        @(negedge read_clk);
        bus.flush = 1'b1;
        #1;
        checkOutput("pf_second_read", 64'(bus.Read_enable), 64'h1);
        @(negedge read_clk);
        bus.flush = 1'b0;
        #1;
        checkOutput("pf_reads_stop", 64'(bus.Read_enable), 64'h0);
        checkOutput("pf_not_yet",    64'(bus.word_valid),  64'h0);
        @(negedge read_clk);
        checkOutput("pf_valid", 64'(bus.word_valid), 64'h1);
        checkOutput("pf_word",  64'(bus.word_out),   64'h00004433);
        checkOutput("pf_bytes", 64'(bus.word_bytes), 64'd2);
        repeat (3) begin
            @(negedge read_clk);
            checkOutput("pf_hold_no_read", 64'(bus.Read_enable), 64'h0);
        end
        bus.word_ready = 1'b1;
        @(negedge read_clk);
        checkOutput("pf_accept", 64'(bus.word_valid), 64'h0);

        // Three captures, then reset mid-word
        applyStimulus(8'h66);
        applyStimulus(8'h77);
        repeat (6) @(negedge read_clk);
        checkOutput("mid_no_word", 64'(bus.word_valid),  64'h0);
        checkOutput("mid_idle",    64'(bus.Read_enable), 64'h0);
        reset = 1'b0;
        @(negedge read_clk);
        checkOutput("mid_rst_word",  64'(bus.word_out),   64'h0);
        checkOutput("mid_rst_valid", 64'(bus.word_valid), 64'h0);
        @(negedge read_clk);
        applyStimulus(8'hA1);
        applyStimulus(8'hB2);
        applyStimulus(8'hC3);
        applyStimulus(8'hD4);
        reset = 1'b1;
        #1;
        waitValid(20, reads, cycles);
        checkOutput("mid_valid",  64'(bus.word_valid), 64'h1);
        checkOutput("mid_reads",  64'(reads),          64'd4);
        checkOutput("mid_cycles", 64'(cycles),         64'd5);
        checkOutput("mid_word",   64'(bus.word_out),   64'hD4C3B2A1);
        checkOutput("mid_bytes",  64'(bus.word_bytes), 64'd4);
        @(negedge read_clk);
        checkOutput("mid_accept", 64'(bus.word_valid), 64'h0);

        // Flush coinciding with the capture that completes a word
        bus.word_ready = 1'b0;
        applyStimulus(8'hE0);
        applyStimulus(8'hE1);
        applyStimulus(8'hE2);
        applyStimulus(8'hE3);
        #1;
        repeat (4) @(negedge read_clk);
        bus.flush = 1'b1;
        @(negedge read_clk);
        bus.flush = 1'b0;
        checkOutput("ff_valid", 64'(bus.word_valid), 64'h1);
        checkOutput("ff_word",  64'(bus.word_out),   64'hE3E2E1E0);
        checkOutput("ff_bytes", 64'(bus.word_bytes), 64'd4);
        bus.word_ready = 1'b1;
        @(negedge read_clk);
        checkOutput("ff_accept", 64'(bus.word_valid), 64'h0);
        applyStimulus(8'hF1);
        #1;
        checkOutput("ff_flush_dropped", 64'(bus.Read_enable), 64'h1);
        repeat (2) @(negedge read_clk);
        checkOutput("ff_no_word", 64'(bus.word_valid), 64'h0);

        checkOutput("fifo_underflow", 64'(underflow), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
